// File: rtl/axil_master_arbiter_if.sv
// AXI-Lite channel bundle shared by the arbiter's requester ports and its
// downstream master bus. The slave modport is the requester side as seen
// from the arbiter, and the master modport is the downstream bus.
interface axil_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport m_axil (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport s_axil (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_master_arbiter.sv
// Two-port AXI-Lite master arbiter. One whole transaction is granted at a
// time, with round-robin between ports and writes ahead of reads within a
// port. A response watchdog answers a stalled requester with SLVERR and then
// drains the late downstream response so the shared bus stays in step.
module axil_master_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic   aclk,
  input  logic   areset,
  axil_if.s_axil s0_axil,
  axil_if.s_axil s1_axil,
  axil_if.m_axil m_axil,
  output logic   busy,
  output logic   grant,
  output logic   timeout
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DRAIN_B, DRAIN_R
  } state_t;

  state_t           state_reg;
  logic             grant_reg;
  logic             last_grant_reg;
  logic             aw_done_reg;
  logic             w_done_reg;
  logic             to_flag_reg;
  logic             timeout_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Requester inputs gathered into port-indexed arrays
  logic [1:0]            s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [ADDR_WIDTH-1:0] s_awaddr [2];
  logic [ADDR_WIDTH-1:0] s_araddr [2];
  logic [DATA_WIDTH-1:0] s_wdata  [2];
  logic [STRB_W-1:0]     s_wstrb  [2];

  assign s_awvalid   = {s1_axil.awvalid, s0_axil.awvalid};
  assign s_wvalid    = {s1_axil.wvalid,  s0_axil.wvalid};
  assign s_bready    = {s1_axil.bready,  s0_axil.bready};
  assign s_arvalid   = {s1_axil.arvalid, s0_axil.arvalid};
  assign s_rready    = {s1_axil.rready,  s0_axil.rready};
  assign s_awaddr[0] = s0_axil.awaddr;
  assign s_awaddr[1] = s1_axil.awaddr;
  assign s_araddr[0] = s0_axil.araddr;
  assign s_araddr[1] = s1_axil.araddr;
  assign s_wdata[0]  = s0_axil.wdata;
  assign s_wdata[1]  = s1_axil.wdata;
  assign s_wstrb[0]  = s0_axil.wstrb;
  assign s_wstrb[1]  = s1_axil.wstrb;

  // Outputs computed locally, then driven onto the interfaces
  logic [1:0]            s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]            s_bresp [2];
  logic [1:0]            s_rresp [2];
  logic [DATA_WIDTH-1:0] s_rdata [2];
  logic [ADDR_WIDTH-1:0] m_awaddr, m_araddr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_W-1:0]     m_wstrb;
  logic                  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  assign s0_axil.awready = s_awready[0];
  assign s0_axil.wready  = s_wready[0];
  assign s0_axil.bvalid  = s_bvalid[0];
  assign s0_axil.bresp   = s_bresp[0];
  assign s0_axil.arready = s_arready[0];
  assign s0_axil.rvalid  = s_rvalid[0];
  assign s0_axil.rdata   = s_rdata[0];
  assign s0_axil.rresp   = s_rresp[0];
  assign s1_axil.awready = s_awready[1];
  assign s1_axil.wready  = s_wready[1];
  assign s1_axil.bvalid  = s_bvalid[1];
  assign s1_axil.bresp   = s_bresp[1];
  assign s1_axil.arready = s_arready[1];
  assign s1_axil.rvalid  = s_rvalid[1];
  assign s1_axil.rdata   = s_rdata[1];
  assign s1_axil.rresp   = s_rresp[1];
  assign m_axil.awaddr   = m_awaddr;
  assign m_axil.awvalid  = m_awvalid;
  assign m_axil.wdata    = m_wdata;
  assign m_axil.wstrb    = m_wstrb;
  assign m_axil.wvalid   = m_wvalid;
  assign m_axil.bready   = m_bready;
  assign m_axil.araddr   = m_araddr;
  assign m_axil.arvalid  = m_arvalid;
  assign m_axil.rready   = m_rready;

  assign busy    = (state_reg != IDLE);
  assign grant   = grant_reg;
  assign timeout = timeout_reg;

  // Arbitration: on a tie the port that was not served last wins
  logic [1:0] req;
  logic       sel;
  assign req = s_awvalid | s_arvalid;
  assign sel = (&req) ? ~last_grant_reg : req[1];

  // Handshakes seen on each side of the arbiter
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs, req_resp_hs, resp_valid, resp_hs;
  assign aw_hs       = m_awvalid & m_axil.awready;
  assign w_hs        = m_wvalid & m_axil.wready;
  assign ar_hs       = m_arvalid & m_axil.arready;
  assign b_hs        = m_axil.bvalid & m_bready;
  assign r_hs        = m_axil.rvalid & m_rready;
  assign req_resp_hs = (s_bvalid[grant_reg] & s_bready[grant_reg]) |
                       (s_rvalid[grant_reg] & s_rready[grant_reg]);
  assign resp_valid  = (state_reg == WR_RESP) ? m_axil.bvalid : m_axil.rvalid;
  assign resp_hs     = (state_reg == WR_RESP) ? b_hs : r_hs;

  // Channel routing: only the granted port's active phase is passed through
  always_comb begin
    m_awaddr   = '0;
    m_awvalid  = 1'b0;
    m_wdata    = '0;
    m_wstrb    = '0;
    m_wvalid   = 1'b0;
    m_bready   = 1'b0;
    m_araddr   = '0;
    m_arvalid  = 1'b0;
    m_rready   = 1'b0;
    s_awready  = '0;
    s_wready   = '0;
    s_bvalid   = '0;
    s_arready  = '0;
    s_rvalid   = '0;
    s_bresp[0] = '0;
    s_bresp[1] = '0;
    s_rresp[0] = '0;
    s_rresp[1] = '0;
    s_rdata[0] = '0;
    s_rdata[1] = '0;
    case (state_reg)
      WR_ADDR: begin
        m_awaddr             = s_awaddr[grant_reg];
        m_awvalid            = s_awvalid[grant_reg] & ~aw_done_reg;
        s_awready[grant_reg] = m_axil.awready & ~aw_done_reg;
        m_wdata              = s_wdata[grant_reg];
        m_wstrb              = s_wstrb[grant_reg];
        m_wvalid             = s_wvalid[grant_reg] & ~w_done_reg;
        s_wready[grant_reg]  = m_axil.wready & ~w_done_reg;
      end
      WR_RESP: begin
        if (to_flag_reg) begin
          s_bvalid[grant_reg] = 1'b1;
          s_bresp[grant_reg]  = RESP_SLVERR;
        end else begin
          s_bvalid[grant_reg] = m_axil.bvalid;
          s_bresp[grant_reg]  = m_axil.bresp;
          m_bready            = s_bready[grant_reg];
        end
      end
      RD_ADDR: begin
        m_araddr             = s_araddr[grant_reg];
        m_arvalid            = s_arvalid[grant_reg];
        s_arready[grant_reg] = m_axil.arready;
      end
      RD_DATA: begin
        if (to_flag_reg) begin
          s_rvalid[grant_reg] = 1'b1;
          s_rresp[grant_reg]  = RESP_SLVERR;
        end else begin
          s_rvalid[grant_reg] = m_axil.rvalid;
          s_rdata[grant_reg]  = m_axil.rdata;
          s_rresp[grant_reg]  = m_axil.rresp;
          m_rready            = s_rready[grant_reg];
        end
      end
      DRAIN_B: m_bready = 1'b1;
      DRAIN_R: m_rready = 1'b1;
      default: ;
    endcase
  end

  // Transaction FSM with response watchdog
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
      to_flag_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      cnt_reg        <= '0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|req) begin
            grant_reg <= sel;
            state_reg <= s_awvalid[sel] ? WR_ADDR : RD_ADDR;
          end
        end
        WR_ADDR: begin
          if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) begin
            state_reg   <= WR_RESP;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            cnt_reg     <= '0;
            to_flag_reg <= 1'b0;
          end else begin
            if (aw_hs) aw_done_reg <= 1'b1;
            if (w_hs)  w_done_reg  <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            state_reg   <= RD_DATA;
            cnt_reg     <= '0;
            to_flag_reg <= 1'b0;
          end
        end
        WR_RESP, RD_DATA: begin
          if (to_flag_reg) begin
            // Local error response is out; wait for the requester to take it
            if (req_resp_hs) begin
              state_reg   <= (state_reg == WR_RESP) ? DRAIN_B : DRAIN_R;
              to_flag_reg <= 1'b0;
            end
          end else if (resp_hs) begin
            state_reg      <= IDLE;
            last_grant_reg <= grant_reg;
          end else if (!resp_valid) begin
            if (cnt_reg == CNT_LAST) begin
              to_flag_reg    <= 1'b1;
              timeout_reg    <= 1'b1;
              last_grant_reg <= grant_reg;
            end
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DRAIN_B: if (b_hs) state_reg <= IDLE;
        DRAIN_R: if (r_hs) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed self-checking bench for axil_master_arbiter (watchdog set to 16).
module tb_axil_master_arbiter;

  logic aclk = 1'b0;
  logic areset;
  logic busy, grant, timeout;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 aclk = ~aclk;

  axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s0_if ();
  axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s1_if ();
  axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

  axil_master_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s0_axil(s0_if), .s1_axil(s1_if), .m_axil(m_if),
    .busy(busy), .grant(grant), .timeout(timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_wr(input int p, input logic v, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      s0_if.awvalid = v; s0_if.wvalid = v; s0_if.awaddr = a; s0_if.wdata = d; s0_if.wstrb = 4'hF;
    end else begin
      s1_if.awvalid = v; s1_if.wvalid = v; s1_if.awaddr = a; s1_if.wdata = d; s1_if.wstrb = 4'hF;
    end
  endtask

  task automatic set_rd(input int p, input logic v, input logic [31:0] a);
    if (p == 0) begin s0_if.arvalid = v; s0_if.araddr = a; end
    else        begin s1_if.arvalid = v; s1_if.araddr = a; end
  endtask

  task automatic set_readies(input int p, input logic b, input logic r);
    if (p == 0) begin s0_if.bready = b; s0_if.rready = r; end
    else        begin s1_if.bready = b; s1_if.rready = r; end
  endtask

  function automatic logic [31:0] bvalid_of(input int p);
    return (p == 0) ? 32'(s0_if.bvalid) : 32'(s1_if.bvalid);
  endfunction
  function automatic logic [31:0] bresp_of(input int p);
    return (p == 0) ? 32'(s0_if.bresp) : 32'(s1_if.bresp);
  endfunction
  function automatic logic [31:0] rvalid_of(input int p);
    return (p == 0) ? 32'(s0_if.rvalid) : 32'(s1_if.rvalid);
  endfunction
  function automatic logic [31:0] rdata_of(input int p);
    return (p == 0) ? s0_if.rdata : s1_if.rdata;
  endfunction

  // Serve the next write, expected to come from port p, with an always-ready slave
  task automatic finish_write(input int p, input logic [31:0] a, input logic [31:0] d, input string tag);
    int n;
    n = 0;
    m_if.awready = 1'b1;
    m_if.wready  = 1'b1;
    @(negedge aclk);
    while (m_if.awvalid !== 1'b1 && n < 8) begin
      @(negedge aclk);
      n++;
    end
    check({tag, ".awvalid"}, 32'(m_if.awvalid), 32'd1);
    check({tag, ".grant"},   32'(grant), 32'(p));
    check({tag, ".awaddr"},  m_if.awaddr, a);
    check({tag, ".wdata"},   m_if.wdata, d);
    check({tag, ".arvalid"}, 32'(m_if.arvalid), 32'd0);
    to_pos();
    set_wr(p, 1'b0, 32'd0, 32'd0);
    m_if.awready = 1'b0;
    m_if.wready  = 1'b0;
    m_if.bvalid  = 1'b1;
    m_if.bresp   = 2'b00;
    set_readies(p, 1'b1, 1'b0);
    @(negedge aclk);
    check({tag, ".bvalid"}, bvalid_of(p), 32'd1);
    check({tag, ".bresp"},  bresp_of(p), 32'd0);
    to_pos();
    m_if.bvalid = 1'b0;
    set_readies(p, 1'b0, 1'b0);
    $display("write port=%0d addr=%08h data=%08h", p, a, d);
  endtask

  // Serve the next read, expected to come from port p
  task automatic finish_read(input int p, input logic [31:0] a, input logic [31:0] d, input string tag);
    int n;
    n = 0;
    m_if.arready = 1'b1;
    @(negedge aclk);
    while (m_if.arvalid !== 1'b1 && n < 8) begin
      @(negedge aclk);
      n++;
    end
    check({tag, ".arvalid"}, 32'(m_if.arvalid), 32'd1);
    check({tag, ".grant"},   32'(grant), 32'(p));
    check({tag, ".araddr"},  m_if.araddr, a);
    check({tag, ".awvalid"}, 32'(m_if.awvalid), 32'd0);
    to_pos();
    set_rd(p, 1'b0, 32'd0);
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b1;
    m_if.rdata   = d;
    m_if.rresp   = 2'b00;
    set_readies(p, 1'b0, 1'b1);
    @(negedge aclk);
    check({tag, ".rvalid"}, rvalid_of(p), 32'd1);
    check({tag, ".rdata"},  rdata_of(p), d);
    to_pos();
    m_if.rvalid = 1'b0;
    m_if.rdata  = 32'd0;
    set_readies(p, 1'b0, 1'b0);
    $display("read  port=%0d addr=%08h data=%08h", p, a, d);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic early;
    areset = 1'b1;
    set_wr(0, 1'b0, 32'd0, 32'd0);
    set_wr(1, 1'b0, 32'd0, 32'd0);
    set_rd(0, 1'b0, 32'd0);
    set_rd(1, 1'b0, 32'd0);
    set_readies(0, 1'b0, 1'b0);
    set_readies(1, 1'b0, 1'b0);
    m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.arready = 1'b0;
    m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
    m_if.rvalid = 1'b0; m_if.rdata = 32'd0; m_if.rresp = 2'b00;
    repeat (3) @(posedge aclk);
    #1;
    areset = 1'b0;

    // Reset state
    @(negedge aclk);
    check("rst.busy",      32'(busy), 32'd0);
    check("rst.grant",     32'(grant), 32'd0);
    check("rst.timeout",   32'(timeout), 32'd0);
    check("rst.m_awvalid", 32'(m_if.awvalid), 32'd0);
    check("rst.m_bready",  32'(m_if.bready), 32'd0);
    check("rst.s0_bvalid", 32'(s0_if.bvalid), 32'd0);
    $display("reset done");

    // Single write on port 0, slave takes AW one cycle before W
    to_pos();
    set_wr(0, 1'b1, 32'h10, 32'hDEADBEEF);
    m_if.awready = 1'b1;
    m_if.wready  = 1'b0;
    @(negedge aclk);
    check("t1.idle_awvalid", 32'(m_if.awvalid), 32'd0);
    to_pos();
    @(negedge aclk);
    check("t1.awvalid",    32'(m_if.awvalid), 32'd1);
    check("t1.awaddr",     m_if.awaddr, 32'h10);
    check("t1.wvalid",     32'(m_if.wvalid), 32'd1);
    check("t1.wdata",      m_if.wdata, 32'hDEADBEEF);
    check("t1.wstrb",      32'(m_if.wstrb), 32'hF);
    check("t1.s0_awready", 32'(s0_if.awready), 32'd1);
    check("t1.s0_wready0", 32'(s0_if.wready), 32'd0);
    check("t1.s1_awready", 32'(s1_if.awready), 32'd0);
    check("t1.busy",       32'(busy), 32'd1);
    check("t1.grant",      32'(grant), 32'd0);
    to_pos();
    s0_if.awvalid = 1'b0;
    m_if.awready  = 1'b0;
    m_if.wready   = 1'b1;
    @(negedge aclk);
    check("t1.awvalid_masked", 32'(m_if.awvalid), 32'd0);
    check("t1.s0_wready1",     32'(s0_if.wready), 32'd1);
    to_pos();
    s0_if.wvalid = 1'b0;
    m_if.wready  = 1'b0;
    m_if.bvalid  = 1'b1;
    m_if.bresp   = 2'b00;
    s0_if.bready = 1'b1;
    @(negedge aclk);
    check("t1.s0_bvalid", 32'(s0_if.bvalid), 32'd1);
    check("t1.s0_bresp",  32'(s0_if.bresp), 32'd0);
    check("t1.m_bready",  32'(m_if.bready), 32'd1);
    to_pos();
    m_if.bvalid  = 1'b0;
    s0_if.bready = 1'b0;
    @(negedge aclk);
    check("t1.busy_after", 32'(busy), 32'd0);
    check("t1.grant_after", 32'(grant), 32'd0);
    $display("write port=0 addr=00000010 data=deadbeef (AW before W)");

    // Round-robin: fresh reset, simultaneous writes
    areset = 1'b1;
    to_pos();
    areset = 1'b0;
    set_wr(0, 1'b1, 32'h100, 32'h00000A00);
    set_wr(1, 1'b1, 32'h104, 32'h00000B01);
    finish_write(0, 32'h100, 32'h00000A00, "t2a");
    finish_write(1, 32'h104, 32'h00000B01, "t2b");
    set_wr(0, 1'b1, 32'h108, 32'h00000A02);
    finish_write(0, 32'h108, 32'h00000A02, "t2c");
    set_wr(0, 1'b1, 32'h10C, 32'h00000A03);
    set_wr(1, 1'b1, 32'h110, 32'h00000B04);
    finish_write(1, 32'h110, 32'h00000B04, "t2d");
    finish_write(0, 32'h10C, 32'h00000A03, "t2e");

    // Port 1 write and read together: write first, then read
    set_wr(1, 1'b1, 32'h24, 32'hA5A5A5A5);
    set_rd(1, 1'b1, 32'h20);
    finish_write(1, 32'h24, 32'hA5A5A5A5, "t3wr");
    finish_read(1, 32'h20, 32'h12345678, "t3rd");

    // Watchdog: slave never answers until cycle 40 after entering WR_RESP
    set_wr(0, 1'b1, 32'h30, 32'h55AA55AA);
    m_if.awready = 1'b1;
    m_if.wready  = 1'b1;
    @(negedge aclk);
    for (int n = 0; n < 8 && m_if.awvalid !== 1'b1; n++) @(negedge aclk);
    check("t4.awvalid", 32'(m_if.awvalid), 32'd1);
    to_pos();
    set_wr(0, 1'b0, 32'd0, 32'd0);
    m_if.awready = 1'b0;
    m_if.wready  = 1'b0;
    early = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge aclk);
      if (timeout !== 1'b0 || s0_if.bvalid !== 1'b0) early = 1'b1;
      to_pos();
    end
    @(negedge aclk);
    check("t4.early",       32'(early), 32'd0);
    check("t4.timeout",     32'(timeout), 32'd1);
    check("t4.s0_bvalid",   32'(s0_if.bvalid), 32'd1);
    check("t4.s0_bresp",    32'(s0_if.bresp), 32'd2);
    check("t4.m_bready",    32'(m_if.bready), 32'd0);
    to_pos();
    s0_if.bready = 1'b1;
    @(negedge aclk);
    check("t4.timeout_pulse", 32'(timeout), 32'd0);
    check("t4.bvalid_held",   32'(s0_if.bvalid), 32'd1);
    to_pos();
    s0_if.bready = 1'b0;
    @(negedge aclk);
    check("t4.drain_s0_bvalid", 32'(s0_if.bvalid), 32'd0);
    check("t4.drain_m_bready",  32'(m_if.bready), 32'd1);
    check("t4.drain_busy",      32'(busy), 32'd1);
    for (int c = 18; c < 40; c++) to_pos();
    m_if.bvalid = 1'b1;
    m_if.bresp  = 2'b00;
    @(negedge aclk);
    check("t4.late_s0_bvalid", 32'(s0_if.bvalid), 32'd0);
    to_pos();
    m_if.bvalid = 1'b0;
    @(negedge aclk);
    check("t4.idle_busy", 32'(busy), 32'd0);
    $display("write port=0 addr=00000030 timed out, late response drained");
    set_wr(0, 1'b1, 32'h34, 32'h0BADF00D);
    finish_write(0, 32'h34, 32'h0BADF00D, "t4next");

    // Reset while port 1 read data is pending
    set_rd(1, 1'b1, 32'h60);
    m_if.arready = 1'b1;
    @(negedge aclk);
    for (int n = 0; n < 8 && m_if.arvalid !== 1'b1; n++) @(negedge aclk);
    check("t5.grant", 32'(grant), 32'd1);
    to_pos();
    set_rd(1, 1'b0, 32'd0);
    m_if.arready = 1'b0;
    m_if.rvalid  = 1'b1;
    m_if.rdata   = 32'h11112222;
    @(negedge aclk);
    check("t5.s1_rvalid", 32'(s1_if.rvalid), 32'd1);
    areset = 1'b1;
    to_pos();
    @(negedge aclk);
    check("t5.rst_busy",      32'(busy), 32'd0);
    check("t5.rst_grant",     32'(grant), 32'd0);
    check("t5.rst_s1_rvalid", 32'(s1_if.rvalid), 32'd0);
    check("t5.rst_s1_rdata",  s1_if.rdata, 32'd0);
    check("t5.rst_m_rready",  32'(m_if.rready), 32'd0);
    to_pos();
    areset = 1'b0;
    m_if.rvalid = 1'b0;
    m_if.rdata  = 32'd0;
    $display("reset during read data");
    set_rd(0, 1'b1, 32'h40);
    finish_read(0, 32'h40, 32'hCAFEF00D, "t5rd");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
